pattern_detect_ctrl: RTL

//  Run-time configurable serial pattern detector and controller. Generalises the fixed
//  1010 detectors: software loads a pattern, length, overlap mode and match target, then

---
 rtl/pattern_detect_pkg.sv | 18 +
 rtl/pattern_shift_match.sv | 65 ++++++
 rtl/pattern_detect_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pattern_detect_pkg.sv
// Shared types and defaults for the configurable serial pattern detector.
package pattern_detect_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A pattern length is usable only when it is 1..pat_w.
  function automatic logic len_ok(input int len, input int pat_w);
    return (len >= 1) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/pattern_shift_match.sv
// History shift register, bits-seen counter and masked compare against the loaded pattern.
module pattern_shift_match #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_hist,
  input  logic             shift_en,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  localparam logic [LEN_W-1:0] SEEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] history_q, history_d;
  logic [LEN_W-1:0] bits_seen_q, bits_seen_d;
  logic [PAT_W-1:0] hist_new;
  logic [PAT_W-1:0] mask;
  logic [LEN_W:0]   seen_inc;

  // NOTE: every variable assigned here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    hist_new = {history_q[PAT_W-2:0], x};
    seen_inc = {1'b0, bits_seen_q} + 1'b1;
    mask     = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && (len != '0) && (seen_inc >= {1'b0, len}) &&
          (((hist_new ^ pattern) & mask) == '0);

    history_d   = history_q;
    bits_seen_d = bits_seen_q;
    if (clear_hist) begin
      history_d   = '0;
      bits_seen_d = '0;
    end else if (shift_en) begin
      history_d = hist_new;
      // Non-overlapping mode demands len fresh bits before the next match.
      if (hit && !overlap) begin
        bits_seen_d = '0;
      end else if (bits_seen_q < SEEN_MAX) begin
        bits_seen_d = bits_seen_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      history_q   <= '0;
      bits_seen_q <= '0;
    end else begin
      history_q   <= history_d;
      bits_seen_q <= bits_seen_d;
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Run-time configurable serial pattern detector: config registers, run FSM and match counter.
module pattern_detect_ctrl
  import pattern_detect_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             x_valid,
  input  logic             x,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match_q, match_d;

  logic cfg_fire;
  logic run_start;
  logic shift_en;
  logic hit;

  assign cfg_ready = (state_q != ST_RUN);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign shift_en  = (state_q == ST_RUN) && x_valid && !stop;

  pattern_shift_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shift_match (
    .clk        (clk),
    .rst        (rst),
    .clear_hist (run_start),
    .shift_en   (shift_en),
    .x          (x),
    .pattern    (pattern_q),
    .len        (len_q),
    .overlap    (overlap_q),
    .hit        (hit)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    cfg_err_d = cfg_err_q;
    count_d   = count_q;
    match_d   = 1'b0;
    run_start = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          match_d = 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
          if ((target_q != '0) && (count_d == target_q)) state_d = ST_DONE;
        end
      end
      default: begin
        // Stop beats a config write, which beats start; a never-configured len of 0 blocks start.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cfg_fire) begin
          pattern_d = cfg_pattern;
          len_d     = cfg_len;
          overlap_d = cfg_overlap;
          target_d  = cfg_target;
          cfg_err_d = !len_ok(int'(cfg_len), PAT_W);
          state_d   = ST_IDLE;
        end else if (start && len_ok(int'(len_q), PAT_W)) begin
          state_d   = ST_RUN;
          count_d   = '0;
          run_start = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
      cfg_err_q <= 1'b0;
      count_q   <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
      match_q   <= match_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign match       = match_q;
  assign match_count = count_q;
  assign cfg_err     = cfg_err_q;

endmodule
